axis_video_framer: RTL and testbench
====================================

Name: axis_video_framer

Overview:
- Output stage directly downstream of access_control's m_axis master port.
- Takes the upsampled pixel stream, re-frames it as a video AXI4-Stream: tuser on the first beat of each frame, tlast on the last beat of each line.
- Registered, skid-buffered output with full backpressure support.
- Checks input tlast against the expected frame length, counts completed frames, and pulses on each frame end.

Parameters:
- DATA_WIDTH, 24, pixel beat width in bits; equals AXISOUT_DATA_WIDTH.
- DST_IMG_WIDTH, 3840, output beats per line.
- DST_IMG_HEIGHT, 2160, lines per frame.
- CNT_WIDTH, 16, width of the column/row counters and frame_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  level; framing runs while high.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tlast  in  1  input end-of-frame marker.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tlast  out  1  end of line.
- m_axis_tuser  out  1  start of frame.
- frame_done  out  1  one-cycle pulse.
- tlast_err  out  1  sticky framing error.
- frame_cnt  out  CNT_WIDTH  frames completed, wraps.

Behaviour:
- Reset is asynchronous, active-high; clk and rst are the only clock and reset. On rst:
  - state=IDLE; col=0, row=0.
  - Skid buffer empty.
  - All outputs 0, including s_axis_tready, frame_done, tlast_err and frame_cnt.
- States:
  - IDLE: s_axis_tready=0. Goes to RUN on enable=1.
  - RUN: accepts beats.
  - After the final beat of a frame is accepted on the input: go to DRAIN if enable=0, else stay in RUN.
  - DRAIN: s_axis_tready=0 until the skid buffer is empty, then IDLE.
  - Deasserting enable mid-frame has no effect until the frame completes.
- Datapath: 2-entry skid buffer (output register plus skid register).
  - s_axis_tready is registered; it is 1 in RUN when the skid register is empty.
  - Latency input->output is 1 cycle when the output is empty.
  - Throughput is 1 beat/cycle with m_axis_tready held at 1.
- AXIS rules:
  - Once m_axis_tvalid=1, tdata/tlast/tuser stay stable until m_axis_tready=1.
  - No bubble inserted while both registers hold data.
- Framing: the tags are computed at input acceptance and travel with the beat.
  - tuser=1 iff col==0 and row==0.
  - tlast=1 iff col==DST_IMG_WIDTH-1.
  - col increments per accepted beat and wraps to 0 at DST_IMG_WIDTH-1.
  - row increments on col wrap and wraps to 0 at DST_IMG_HEIGHT-1.
- Final beat: col==W-1 and row==H-1.
  - When the final beat is accepted: frame_cnt+=1, wrapping modulo 2^CNT_WIDTH.
  - frame_done pulses in the cycle that beat is transferred on m_axis.
- tlast check: tlast_err is set the cycle after acceptance in either case:
  - s_axis_tlast=1 on a non-final beat, or
  - s_axis_tlast=0 on the final beat.
- On a tlast error the beat still passes, and the counters keep their internal sequence (no resync).
- tlast_err clears only on rst.
- Simultaneous acceptance and output transfer in one cycle: the buffer occupancy is unchanged, with no loss or duplication.

Test Plan (W=4, H=2, CNT_WIDTH=8):
- rst=1 mid-frame after 3 beats -> all outputs 0 immediately. After release and enable=1, the next accepted beat carries tuser=1; col and row restart from 0.
- enable=1, 8 beats D0..D7 with m_axis_tready=1 and tlast on D7:
  - Each D0..D7 appears 1 cycle after acceptance.
  - tuser only on D0; tlast on D3 and D7.
  - frame_done pulses with D7; frame_cnt=1; tlast_err=0.
- m_axis_tready toggled 1/0 every cycle, random s_axis_tvalid over 3 frames -> output order preserved, no drops or duplicates, frame_cnt=3.
- s_axis_tlast asserted on beat 5 of 8 -> tlast_err=1 from the next cycle and stays set. Framing is unchanged: tlast still on beats 3 and 7.
- enable dropped after beat 2 -> the frame completes all 8 beats. After D7 drains, state=IDLE and s_axis_tready=0.
- 256 frames -> frame_cnt wraps to 0 and frame_done still pulses every frame.

Source files
------------

// File: rtl/axis_video_framer.sv
// Video AXI4-Stream output framer: tags each beat with start-of-frame/end-of-line,
// checks input tlast against the frame geometry and counts frames, behind a 2-entry skid buffer.
module axis_video_framer #(
    parameter int unsigned DATA_WIDTH     = 24,
    parameter int unsigned DST_IMG_WIDTH  = 3840,
    parameter int unsigned DST_IMG_HEIGHT = 2160,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  frame_done,
    output logic                  tlast_err,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);
    localparam logic [CNT_WIDTH-1:0] ColMax = CNT_WIDTH'(DST_IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] RowMax = CNT_WIDTH'(DST_IMG_HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  col;
    logic [CNT_WIDTH-1:0]  row;

    logic                  m_final;
    logic                  skid_valid;
    logic                  skid_last;
    logic                  skid_user;
    logic                  skid_final;
    logic [DATA_WIDTH-1:0] skid_data;

    logic accept;
    logic in_user;
    logic in_last;
    logic in_final;
    logic out_ready;
    logic skid_valid_next;

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign in_user   = (col == '0) && (row == '0);
    assign in_last   = (col == ColMax);
    assign in_final  = in_last && (row == RowMax);
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    // The skid register is occupied next cycle only while the output register stays stalled.
    assign skid_valid_next = !out_ready && (skid_valid || accept);
    assign frame_done      = m_axis_tvalid && m_axis_tready && m_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            s_axis_tready <= 1'b0;
            col           <= '0;
            row           <= '0;
            frame_cnt     <= '0;
            tlast_err     <= 1'b0;
        end else begin
            if (accept) begin
                if (in_last) begin
                    col <= '0;
                    row <= (row == RowMax) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (in_final) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
                // The beat still passes on a mismatch; the counters never resync.
                if (s_axis_tlast != in_final) begin
                    tlast_err <= 1'b1;
                end
            end
            unique case (state)
                StIdle: begin
                    if (enable) begin
                        state         <= StRun;
                        s_axis_tready <= 1'b1;
                    end
                end
                StRun: begin
                    if (accept && in_final && !enable) begin
                        state         <= StDrain;
                        s_axis_tready <= 1'b0;
                    end else begin
                        s_axis_tready <= !skid_valid_next;
                    end
                end
                StDrain: begin
                    s_axis_tready <= 1'b0;
                    if (!m_axis_tvalid && !skid_valid) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state         <= StIdle;
                    s_axis_tready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_final       <= 1'b0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            skid_last     <= 1'b0;
            skid_user     <= 1'b0;
            skid_final    <= 1'b0;
        end else if (out_ready) begin
            if (skid_valid) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= skid_data;
                m_axis_tlast  <= skid_last;
                m_axis_tuser  <= skid_user;
                m_final       <= skid_final;
                skid_valid    <= 1'b0;
            end else if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= in_last;
                m_axis_tuser  <= in_user;
                m_final       <= in_final;
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= s_axis_tdata;
            skid_last  <= in_last;
            skid_user  <= in_user;
            skid_final <= in_final;
        end
    end
endmodule

// File: tb/tb_axis_video_framer.sv
// Directed bench for axis_video_framer with a 4x2 frame and an 8-bit frame counter.
module tb_axis_video_framer;
    localparam int unsigned DW = 24;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          frame_done;
    logic          tlast_err;
    logic [CW-1:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fd_count = 0;
    logic [DW+2:0] out_q[$];
    int out_cyc_q[$];
    int acc_cyc_q[$];
    bit tog_stop;

    axis_video_framer #(
        .DATA_WIDTH(DW),
        .DST_IMG_WIDTH(4),
        .DST_IMG_HEIGHT(2),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .frame_done(frame_done),
        .tlast_err(tlast_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer log: each entry is {frame_done, tuser, tlast, tdata}.
    always @(negedge clk) begin
        if (s_axis_tvalid && s_axis_tready) acc_cyc_q.push_back(cyc);
        if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back({frame_done, m_axis_tuser, m_axis_tlast, m_axis_tdata});
            out_cyc_q.push_back(cyc);
        end
        if (frame_done) fd_count++;
    end

    task automatic apply_reset();
        rst = 1'b1;
        enable = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tdata = '0;
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic last, input bit gap);
        int t;
        if (gap) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        s_axis_tdata = d;
        s_axis_tlast = last;
        s_axis_tvalid = 1'b1;
        t = 0;
        while (!s_axis_tready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!s_axis_tready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got tready=0 want 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input logic [7:0] tl, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            push_beat(DW'(base + DW'(i)), tl[i], gaps ? bit'($urandom_range(0, 1)) : 1'b0);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (m_axis_tvalid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (m_axis_tvalid) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got tvalid=1 want 0");
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int o;
        logic [DW+2:0] exp;
        checks++;
        if ({m_axis_tvalid, s_axis_tready, m_axis_tuser, m_axis_tlast, frame_done, tlast_err}
            !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b want 000000", {m_axis_tvalid, s_axis_tready,
                     m_axis_tuser, m_axis_tlast, frame_done, tlast_err});
        end
        checks++;
        if (frame_cnt !== 8'd0 || m_axis_tdata !== 24'd0) begin
            failures++;
            $display("FAIL reset_data got cnt=%0d data=%h want 0 0", frame_cnt, m_axis_tdata);
        end
        rst = 1'b0;
        enable = 1'b1;
        push_beat(24'h000001, 1'b1, 1'b0);
        push_beat(24'h000002, 1'b0, 1'b0);
        push_beat(24'h000003, 1'b0, 1'b0);
        checks++;
        if (tlast_err !== 1'b1 || m_axis_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_state got err=%b valid=%b want 1 1", tlast_err, m_axis_tvalid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({m_axis_tvalid, s_axis_tready, m_axis_tuser, m_axis_tlast, frame_done, tlast_err}
            !== 6'b0 || m_axis_tdata !== 24'd0) begin
            failures++;
            $display("FAIL async_reset got ctrl=%b data=%h want 000000 0", {m_axis_tvalid,
                     s_axis_tready, m_axis_tuser, m_axis_tlast, frame_done, tlast_err}, m_axis_tdata);
        end
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        o = out_q.size();
        send_frame(24'h100000, 8'h80, 1'b0);
        wait_drain();
        checks++;
        if (out_q.size() - o !== 8) begin
            failures++;
            $display("FAIL reset_restart_count got %0d want 8", out_q.size() - o);
        end
        for (int i = 0; i < 8; i++) begin
            exp = {(i % 8 == 7), (i % 8 == 0), (i % 4 == 3), DW'(24'h100000 + i)};
            checks++;
            if (out_q[o + i] !== exp) begin
                failures++;
                $display("FAIL reset_restart_beat%0d got %h want %h", i, out_q[o + i], exp);
            end
        end
        checks++;
        if (frame_cnt !== 8'd1 || tlast_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_restart_status got cnt=%0d err=%b want 1 0", frame_cnt, tlast_err);
        end
    endtask

    task automatic test_basic_frame();
        int o, a, f;
        logic [DW+2:0] exp;
        apply_reset();
        enable = 1'b1;
        o = out_q.size();
        a = acc_cyc_q.size();
        f = fd_count;
        send_frame(24'hA00000, 8'h80, 1'b0);
        wait_drain();
        checks++;
        if (out_q.size() - o !== 8) begin
            failures++;
            $display("FAIL basic_count got %0d want 8", out_q.size() - o);
        end
        for (int i = 0; i < 8; i++) begin
            exp = {(i % 8 == 7), (i % 8 == 0), (i % 4 == 3), DW'(24'hA00000 + i)};
            checks++;
            if (out_q[o + i] !== exp) begin
                failures++;
                $display("FAIL basic_beat%0d got %h want %h", i, out_q[o + i], exp);
            end
            checks++;
            if (out_cyc_q[o + i] - acc_cyc_q[a + i] !== 1) begin
                failures++;
                $display("FAIL basic_latency%0d got %0d want 1", i,
                         out_cyc_q[o + i] - acc_cyc_q[a + i]);
            end
        end
        checks++;
        if (fd_count - f !== 1 || frame_cnt !== 8'd1 || tlast_err !== 1'b0) begin
            failures++;
            $display("FAIL basic_status got done=%0d cnt=%0d err=%b want 1 1 0",
                     fd_count - f, frame_cnt, tlast_err);
        end
    endtask

    task automatic test_backpressure();
        int o, f;
        logic [DW+2:0] exp;
        apply_reset();
        enable = 1'b1;
        o = out_q.size();
        f = fd_count;
        tog_stop = 1'b0;
        fork
            begin
                for (int fr = 0; fr < 3; fr++) send_frame(DW'(24'hB00000 + fr * 8), 8'h80, 1'b1);
                tog_stop = 1'b1;
            end
            begin
                while (!tog_stop) begin
                    @(posedge clk); #1;
                    m_axis_tready = ~m_axis_tready;
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_drain();
        checks++;
        if (out_q.size() - o !== 24) begin
            failures++;
            $display("FAIL bp_count got %0d want 24", out_q.size() - o);
        end
        for (int i = 0; i < 24; i++) begin
            exp = {(i % 8 == 7), (i % 8 == 0), (i % 4 == 3), DW'(24'hB00000 + i)};
            checks++;
            if (out_q[o + i] !== exp) begin
                failures++;
                $display("FAIL bp_beat%0d got %h want %h", i, out_q[o + i], exp);
            end
        end
        checks++;
        if (fd_count - f !== 3 || frame_cnt !== 8'd3 || tlast_err !== 1'b0) begin
            failures++;
            $display("FAIL bp_status got done=%0d cnt=%0d err=%b want 3 3 0",
                     fd_count - f, frame_cnt, tlast_err);
        end
    endtask

    task automatic test_tlast_err();
        int o;
        logic [DW+2:0] exp;
        apply_reset();
        enable = 1'b1;
        o = out_q.size();
        for (int i = 0; i < 5; i++) push_beat(DW'(24'hC00000 + i), 1'b0, 1'b0);
        checks++;
        if (tlast_err !== 1'b0) begin
            failures++;
            $display("FAIL err_before got %b want 0", tlast_err);
        end
        push_beat(24'hC00005, 1'b1, 1'b0);
        checks++;
        if (tlast_err !== 1'b1) begin
            failures++;
            $display("FAIL err_next_cycle got %b want 1", tlast_err);
        end
        push_beat(24'hC00006, 1'b0, 1'b0);
        push_beat(24'hC00007, 1'b1, 1'b0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        send_frame(24'hC00008, 8'h80, 1'b0);
        wait_drain();
        for (int i = 0; i < 16; i++) begin
            exp = {(i % 8 == 7), (i % 8 == 0), (i % 4 == 3), DW'(24'hC00000 + i)};
            checks++;
            if (out_q[o + i] !== exp) begin
                failures++;
                $display("FAIL err_beat%0d got %h want %h", i, out_q[o + i], exp);
            end
        end
        checks++;
        if (tlast_err !== 1'b1 || frame_cnt !== 8'd2) begin
            failures++;
            $display("FAIL err_sticky got err=%b cnt=%0d want 1 2", tlast_err, frame_cnt);
        end
    endtask

    task automatic test_enable_drop();
        int o, busy;
        logic [DW+2:0] exp;
        apply_reset();
        enable = 1'b1;
        o = out_q.size();
        push_beat(24'hD00000, 1'b0, 1'b0);
        push_beat(24'hD00001, 1'b0, 1'b0);
        enable = 1'b0;
        for (int i = 2; i < 8; i++) push_beat(DW'(24'hD00000 + i), i == 7, 1'b0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        checks++;
        if (s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL drop_drain_ready got %b want 0", s_axis_tready);
        end
        wait_drain();
        busy = 0;
        for (int i = 0; i < 4; i++) begin
            if (s_axis_tready || m_axis_tvalid) busy++;
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 0) begin
            failures++;
            $display("FAIL drop_idle got busy_cycles=%0d want 0", busy);
        end
        checks++;
        if (out_q.size() - o !== 8 || frame_cnt !== 8'd1) begin
            failures++;
            $display("FAIL drop_count got beats=%0d cnt=%0d want 8 1", out_q.size() - o, frame_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            exp = {(i % 8 == 7), (i % 8 == 0), (i % 4 == 3), DW'(24'hD00000 + i)};
            checks++;
            if (out_q[o + i] !== exp) begin
                failures++;
                $display("FAIL drop_beat%0d got %h want %h", i, out_q[o + i], exp);
            end
        end
    endtask

    task automatic test_wrap();
        int o, f, bad;
        logic [DW+2:0] exp;
        apply_reset();
        enable = 1'b1;
        o = out_q.size();
        f = fd_count;
        for (int fr = 0; fr < 256; fr++) begin
            send_frame(DW'(fr * 8), 8'h80, 1'b0);
            if (fr == 254) begin
                checks++;
                if (frame_cnt !== 8'd255) begin
                    failures++;
                    $display("FAIL wrap_cnt255 got %0d want 255", frame_cnt);
                end
            end
        end
        wait_drain();
        checks++;
        if (frame_cnt !== 8'd0 || fd_count - f !== 256) begin
            failures++;
            $display("FAIL wrap_status got cnt=%0d done=%0d want 0 256", frame_cnt, fd_count - f);
        end
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            exp = {(i % 8 == 7), (i % 8 == 0), (i % 4 == 3), DW'(i)};
            if (out_q[o + i] !== exp) bad++;
        end
        checks++;
        if (bad !== 0 || out_q.size() - o !== 2048) begin
            failures++;
            $display("FAIL wrap_beats got bad=%0d beats=%0d want 0 2048", bad, out_q.size() - o);
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        tog_stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_tlast_err();
        test_enable_drop();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
